// File: rtl/lc3_sequencer_if.sv
// Control/status bundle between the LC-3 sequencer and its datapath.
// The sequencer side is 'master'; the datapath side is 'slave'.
interface lc3_sequencer_if;
  logic [15:0] IR;
  logic        N;
  logic        Z;
  logic        P;
  logic        memRdy;
  logic [1:0]  aluControl;
  logic        enaALU;
  logic        enaMARM;
  logic        enaMDR;
  logic        enaPC;
  logic        selMAR;
  logic        selEAB1;
  logic [1:0]  selEAB2;
  logic [1:0]  selPC;
  logic        selMDR;
  logic        ldPC;
  logic        ldIR;
  logic        ldMAR;
  logic        ldMDR;
  logic [2:0]  SR1;
  logic [2:0]  SR2;
  logic [2:0]  DR;
  logic        regWE;
  logic        memWE;
  logic        halted;

  modport master (
    input  IR, N, Z, P, memRdy,
    output aluControl, enaALU, enaMARM, enaMDR, enaPC, selMAR, selEAB1, selEAB2,
           selPC, selMDR, ldPC, ldIR, ldMAR, ldMDR, SR1, SR2, DR, regWE, memWE, halted
  );

  modport slave (
    output IR, N, Z, P, memRdy,
    input  aluControl, enaALU, enaMARM, enaMDR, enaPC, selMAR, selEAB1, selEAB2,
           selPC, selMDR, ldPC, ldIR, ldMAR, ldMDR, SR1, SR2, DR, regWE, memWE, halted
  );
endinterface

// File: rtl/lc3_sequencer.sv
// Multi-cycle LC-3 control FSM: fetch, decode and execute with memRdy-paced memory waits.
// All control outputs decode combinationally from the state register, IR and memRdy.
module lc3_sequencer (
  input logic             clk,
  input logic             reset,
  lc3_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    FETCH0 = 4'd0,
    FETCH1 = 4'd1,
    FETCH2 = 4'd2,
    DECODE = 4'd3,
    ALU_EX = 4'd4,
    BR_EX  = 4'd5,
    JMP_EX = 4'd6,
    LEA_EX = 4'd7,
    ADDR   = 4'd8,
    IND_RD = 4'd9,
    IND_LD = 4'd10,
    MEM_RD = 4'd11,
    MEM_WB = 4'd12,
    ST_MDR = 4'd13,
    MEM_WR = 4'd14,
    HALT   = 4'd15
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  state_e     state_q;
  state_e     state_d;
  logic [3:0] opcode_s;

  assign opcode_s = bus.IR[15:12];

  // State register; reset parks the machine at the start of fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; while reset is low every output stays 0.
  always_comb begin
    state_d        = state_q;
    bus.aluControl = 2'b00;
    bus.enaALU     = 1'b0;
    bus.enaMARM    = 1'b0;
    bus.enaMDR     = 1'b0;
    bus.enaPC      = 1'b0;
    bus.selMAR     = 1'b0;
    bus.selEAB1    = 1'b0;
    bus.selEAB2    = 2'b00;
    bus.selPC      = 2'b00;
    bus.selMDR     = 1'b0;
    bus.ldPC       = 1'b0;
    bus.ldIR       = 1'b0;
    bus.ldMAR      = 1'b0;
    bus.ldMDR      = 1'b0;
    bus.SR1        = 3'b000;
    bus.SR2        = 3'b000;
    bus.DR         = 3'b000;
    bus.regWE      = 1'b0;
    bus.memWE      = 1'b0;
    bus.halted     = 1'b0;
    if (!reset) begin
      state_d = FETCH0;
    end else begin
      bus.DR  = bus.IR[11:9];
      bus.SR1 = bus.IR[8:6];
      bus.SR2 = bus.IR[2:0];
      case (state_q)
        FETCH0: begin
          bus.enaPC = 1'b1;
          bus.ldMAR = 1'b1;
          bus.ldPC  = 1'b1;
          state_d   = FETCH1;
        end
        FETCH1: begin
          bus.selMDR = 1'b1;
          bus.ldMDR  = bus.memRdy;
          state_d    = bus.memRdy ? FETCH2 : FETCH1;
        end
        FETCH2: begin
          bus.enaMDR = 1'b1;
          bus.ldIR   = 1'b1;
          state_d    = DECODE;
        end
        DECODE: begin
          case (opcode_s)
            OP_ADD, OP_AND, OP_NOT: state_d = ALU_EX;
            OP_BR:                  state_d = BR_EX;
            OP_JMP:                 state_d = JMP_EX;
            OP_LEA:                 state_d = LEA_EX;
            OP_LD, OP_LDR, OP_LDI:  state_d = ADDR;
            OP_ST, OP_STR, OP_STI:  state_d = ADDR;
            default:                state_d = HALT;
          endcase
        end
        ALU_EX: begin
          case (opcode_s)
            OP_AND:  bus.aluControl = 2'b01;
            OP_NOT:  bus.aluControl = 2'b10;
            default: bus.aluControl = 2'b00;
          endcase
          bus.enaALU = 1'b1;
          bus.regWE  = 1'b1;
          state_d    = FETCH0;
        end
        BR_EX: begin
          bus.ldPC    = (bus.IR[11] & bus.N) | (bus.IR[10] & bus.Z) | (bus.IR[9] & bus.P);
          bus.selEAB2 = 2'b10;
          bus.selPC   = 2'b01;
          state_d     = FETCH0;
        end
        JMP_EX: begin
          bus.ldPC    = 1'b1;
          bus.selPC   = 2'b01;
          bus.selEAB1 = 1'b1;
          state_d     = FETCH0;
        end
        LEA_EX: begin
          bus.enaMARM = 1'b1;
          bus.selEAB2 = 2'b10;
          bus.regWE   = 1'b1;
          state_d     = FETCH0;
        end
        ADDR: begin
          bus.enaMARM = 1'b1;
          bus.ldMAR   = 1'b1;
          // Base+offset6 for LDR/STR, PC+offset9 for the rest.
          case (opcode_s)
            OP_LDR: begin
              bus.selEAB1 = 1'b1;
              bus.selEAB2 = 2'b01;
              state_d     = MEM_RD;
            end
            OP_STR: begin
              bus.selEAB1 = 1'b1;
              bus.selEAB2 = 2'b01;
              state_d     = ST_MDR;
            end
            OP_LD: begin
              bus.selEAB2 = 2'b10;
              state_d     = MEM_RD;
            end
            OP_ST: begin
              bus.selEAB2 = 2'b10;
              state_d     = ST_MDR;
            end
            OP_LDI, OP_STI: begin
              bus.selEAB2 = 2'b10;
              state_d     = IND_RD;
            end
            default: begin
              state_d = HALT;
            end
          endcase
        end
        IND_RD: begin
          bus.selMDR = 1'b1;
          bus.ldMDR  = bus.memRdy;
          state_d    = bus.memRdy ? IND_LD : IND_RD;
        end
        IND_LD: begin
          bus.enaMDR = 1'b1;
          bus.ldMAR  = 1'b1;
          if (opcode_s == OP_LDI) begin
            state_d = MEM_RD;
          end else begin
            state_d = ST_MDR;
          end
        end
        MEM_RD: begin
          bus.selMDR = 1'b1;
          bus.ldMDR  = bus.memRdy;
          state_d    = bus.memRdy ? MEM_WB : MEM_RD;
        end
        MEM_WB: begin
          bus.enaMDR = 1'b1;
          bus.regWE  = 1'b1;
          state_d    = FETCH0;
        end
        ST_MDR: begin
          // Source register sits in the DR field for stores; ALU passes it through.
          bus.SR1        = bus.IR[11:9];
          bus.aluControl = 2'b11;
          bus.enaALU     = 1'b1;
          bus.ldMDR      = 1'b1;
          state_d        = MEM_WR;
        end
        MEM_WR: begin
          bus.memWE = 1'b1;
          state_d   = bus.memRdy ? FETCH0 : MEM_WR;
        end
        HALT: begin
          bus.halted = 1'b1;
          state_d    = HALT;
        end
        default: begin
          state_d = FETCH0;
        end
      endcase
    end
  end

endmodule
